// File: rtl/alu_top_pkg.sv
// alu_top_pkg: opcodes, hex-to-segment table and default timing for alu_top.
// Opcode 7 is MUL when ALU_TOP_MUL_EN is defined, otherwise SHR.
package alu_top_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REFRESH_CYCLES_DEF  = 50000;

`ifdef ALU_TOP_MUL_EN
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_MUL
    } op_e;
`else
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
    } op_e;
`endif

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        return HEX_SEG[n];
    endfunction

endpackage

// File: rtl/alu_top_debounce.sv
// alu_top_debounce: 2-FF synchronizer, stability debouncer and one-cycle
// press pulse on the rising edge of the debounced level.
module alu_top_debounce
    import alu_top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          pulse_q;

    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= stable_d & ~stable_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_top.sv
// alu_top: button-loaded 8-bit ALU with LED result and 4-digit 7-segment display.
// Define ALU_TOP_MUL_EN to turn opcode 7 from SHR into MUL.
module alu_top
    import alu_top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REFRESH_CYCLES  = REFRESH_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB0,
    input  logic       PB1,
    input  logic       PB2,
    input  logic [7:0] SW,
    output logic [7:0] LED,
    output logic [3:0] AN,
    output logic [6:0] seg
);

    localparam int RW = $clog2(REFRESH_CYCLES > 1 ? REFRESH_CYCLES : 2);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

    logic [2:0] ld;

    alu_top_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk_i(clk), .rst_ni(rst), .btn_i(PB0), .pulse_o(ld[0])
    );
    alu_top_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk_i(clk), .rst_ni(rst), .btn_i(PB1), .pulse_o(ld[1])
    );
    alu_top_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk_i(clk), .rst_ni(rst), .btn_i(PB2), .pulse_o(ld[2])
    );

    logic [7:0]    a_q, a_d, b_q, b_d, res_q, alu_r;
    op_e           op_q, op_d;
    logic          c_q, z_q, alu_c;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d, nib;
    logic [6:0]    seg_q, seg_d;
    logic          wrap;

    assign a_d  = ld[0] ? SW : a_q;
    assign b_d  = ld[1] ? SW : b_q;
    assign op_d = ld[2] ? op_e'(SW[2:0]) : op_q;

`ifdef ALU_TOP_MUL_EN
    logic [15:0] prod;
    assign prod = {8'h00, a_q} * {8'h00, b_q};
`endif

    always_comb begin
        alu_c = 1'b0;
        alu_r = 8'h00;
        case (op_q)
            OP_ADD: {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: {alu_c, alu_r} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: alu_r = a_q & b_q;
            OP_OR:  alu_r = a_q | b_q;
            OP_XOR: alu_r = a_q ^ b_q;
            OP_NOT: alu_r = ~a_q;
            OP_SHL: {alu_c, alu_r} = {a_q, 1'b0};
`ifdef ALU_TOP_MUL_EN
            OP_MUL: begin
                alu_r = prod[7:0];
                alu_c = |prod[15:8];
            end
`else
            OP_SHR: {alu_r, alu_c} = {1'b0, a_q};
`endif
            default: ;
        endcase
    end

    // AN/seg are derived from the same digit index and registered together
    always_comb begin
        wrap  = ref_q == REF_MAX;
        ref_d = wrap ? '0 : ref_q + RW'(1);
        dig_d = wrap ? dig_q + 2'd1 : dig_q;
        nib   = dig_q == 2'd0 ? res_q[3:0] :
                dig_q == 2'd1 ? res_q[7:4] :
                dig_q == 2'd2 ? {1'b0, op_q} : {2'b00, c_q, z_q};
        an_d  = ~(4'b0001 << dig_q);
        seg_d = hex_seg(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            op_q  <= OP_ADD;
            res_q <= 8'h00;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            ref_q <= '0;
            dig_q <= 2'd0;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            res_q <= alu_r;
            c_q   <= alu_c;
            z_q   <= alu_r == 8'h00;
            ref_q <= ref_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign LED = res_q;
    assign AN  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: randomized self-checking bench for alu_top against an arithmetic model.
module tb_alu_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PB0 = 1'b0, PB1 = 1'b0, PB2 = 1'b0;
    logic [7:0] SW  = 8'h00;
    logic [7:0] LED;
    logic [3:0] AN;
    logic [6:0] seg;

    alu_top #(.DEBOUNCE_CYCLES(16), .REFRESH_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .PB0(PB0), .PB1(PB1), .PB2(PB2),
        .SW(SW), .LED(LED), .AN(AN), .seg(seg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_a = 0, m_b = 0, m_op = 0;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;
            14: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int r, output int c);
        c = 0;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = a / 128; end
`ifdef ALU_TOP_MUL_EN
            default: begin r = (a * b) % 256; c = (a * b > 255) ? 1 : 0; end
`else
            default: begin r = a / 2; c = a % 2; end
`endif
        endcase
    endfunction

    function automatic int exp_led();
        int r, c;
        ref_alu(m_a, m_b, m_op, r, c);
        return r;
    endfunction

    function automatic int exp_nib(input int idx);
        int r, c;
        ref_alu(m_a, m_b, m_op, r, c);
        case (idx)
            0: return r % 16;
            1: return r / 16;
            2: return m_op;
            default: return c * 2 + ((r == 0) ? 1 : 0);
        endcase
    endfunction

    task automatic press(input logic [2:0] mask, input logic [7:0] sw);
        @(negedge clk);
        SW = sw;
        {PB2, PB1, PB0} = mask;
        repeat (40) @(negedge clk);
        {PB2, PB1, PB0} = 3'b000;
        repeat (40) @(negedge clk);
        if (mask[0]) m_a = int'(sw);
        if (mask[1]) m_b = int'(sw);
        if (mask[2]) m_op = int'(sw[2:0]);
    endtask

    // Waits (bounded) until digit idx is lit and returns its segments, X on timeout
    task automatic get_digit(input int idx, output logic [6:0] s);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        s = 7'bx;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (AN === want) begin
                s = seg;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", LED); end
        checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", AN); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (AN !== 4'b1110 || seg !== 7'b1000000) begin
            errors++; $display("FAIL post_reset_disp got=%b/%b exp=1110/1000000", AN, seg);
        end
        repeat (50) @(negedge clk);
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL no_load got=%h exp=00", LED); end
    endtask

    task automatic test_bounce();
        SW = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            PB0 = 1'b1;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            PB0 = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL bounce_ignored got=%h exp=00", LED); end
        PB0 = 1'b1;
        repeat (60) @(negedge clk);
        m_a = 255;
        SW = 8'h11;
        repeat (40) @(negedge clk);
        checks++; if (LED !== 8'(exp_led())) begin
            errors++; $display("FAIL bounce_hold got=%h exp=%h", LED, 8'(exp_led()));
        end
        PB0 = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (LED !== 8'hFF) begin errors++; $display("FAIL bounce_single_load got=%h exp=ff", LED); end
    endtask

    task automatic test_add();
        logic [6:0] s;
        press(3'b001, 8'h32);
        press(3'b010, 8'h4B);
        press(3'b100, 8'h00);
        checks++; if (LED !== 8'h7D || LED !== 8'(exp_led())) begin
            errors++; $display("FAIL add_led got=%h exp=7d", LED);
        end
        for (int d = 0; d < 4; d++) begin
            get_digit(d, s);
            checks++; if (s !== seg_of(exp_nib(d))) begin
                errors++; $display("FAIL add_digit%0d got=%b exp=%b", d, s, seg_of(exp_nib(d)));
            end
        end
    endtask

    task automatic test_ops();
        logic [6:0] s;
        press(3'b001, 8'hFF);
        press(3'b010, 8'h0F);
        for (int op = 1; op < 8; op++) begin
            press(3'b100, 8'(op));
            checks++; if (LED !== 8'(exp_led())) begin
                errors++; $display("FAIL op%0d_led got=%h exp=%h", op, LED, 8'(exp_led()));
            end
            get_digit(3, s);
            checks++; if (s !== seg_of(exp_nib(3))) begin
                errors++; $display("FAIL op%0d_flags got=%b exp=%b", op, s, seg_of(exp_nib(3)));
            end
            get_digit(2, s);
            checks++; if (s !== seg_of(exp_nib(2))) begin
                errors++; $display("FAIL op%0d_opdigit got=%b exp=%b", op, s, seg_of(exp_nib(2)));
            end
        end
    endtask

    task automatic test_refresh();
        logic [3:0] prev;
        int run, idx;
        bit seen_change;
        seen_change = 0;
        run = 1;
        @(negedge clk);
        prev = AN;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (AN !== prev) begin
                checks++; if (AN !== {prev[2:0], prev[3]}) begin
                    errors++; $display("FAIL refresh_order got=%b exp=%b", AN, {prev[2:0], prev[3]});
                end
                if (seen_change) begin
                    checks++; if (run != 4) begin
                        errors++; $display("FAIL refresh_dwell got=%0d exp=4", run);
                    end
                end
                seen_change = 1;
                run = 1;
                prev = AN;
            end else begin
                run++;
            end
            idx = (AN === 4'b1110) ? 0 : (AN === 4'b1101) ? 1 :
                  (AN === 4'b1011) ? 2 : (AN === 4'b0111) ? 3 : -1;
            checks++; if (idx < 0 || seg !== seg_of(exp_nib(idx))) begin
                errors++; $display("FAIL refresh_seg an=%b got=%b exp=%b", AN, seg, seg_of(exp_nib(idx < 0 ? 0 : idx)));
            end
        end
        checks++; if (!seen_change) begin errors++; $display("FAIL refresh_stuck got=%b exp=rotating", AN); end
    endtask

    task automatic test_simultaneous();
        logic [6:0] s;
        press(3'b100, 8'h00);
        press(3'b011, 8'h05);
        checks++; if (LED !== 8'h0A || LED !== 8'(exp_led())) begin
            errors++; $display("FAIL simul_led got=%h exp=0a", LED);
        end
        get_digit(0, s);
        checks++; if (s !== seg_of(10)) begin errors++; $display("FAIL simul_digit0 got=%b exp=%b", s, seg_of(10)); end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [2:0] mask;
        logic [7:0] sw;
        for (int i = 0; i < 10; i++) begin
            mask = 3'($urandom_range(1, 7));
            sw = 8'($urandom);
            press(mask, sw);
            checks++; if (LED !== 8'(exp_led())) begin
                errors++; $display("FAIL rand%0d_led got=%h exp=%h", i, LED, 8'(exp_led()));
            end
            get_digit(3, s);
            checks++; if (s !== seg_of(exp_nib(3))) begin
                errors++; $display("FAIL rand%0d_flags got=%b exp=%b", i, s, seg_of(exp_nib(3)));
            end
            get_digit(1, s);
            checks++; if (s !== seg_of(exp_nib(1))) begin
                errors++; $display("FAIL rand%0d_hi got=%b exp=%b", i, s, seg_of(exp_nib(1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_add();
        test_ops();
        test_refresh();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
